program_loader: RTL
===================

# program_loader

Sequencing controller for the instruction fetch stage and its instruction BRAM. It takes a byte stream from the debug UART receiver, packs bytes into 32-bit instruction words and writes them into instruction memory at sequential addresses. It then drives the fetch/pipeline `enable` in free-run or single-step mode until the pipeline reports halt. It sits between the UART RX and the instruction-memory write port plus the pipeline enable/reset inputs.

## Interface
- `ADDRESS_BITS`, 8: instruction-memory address width; depth is 2^ADDRESS_BITS words.
- `DATA_BITS`, 32: instruction word width; must be a multiple of 8.
- `clk`  in  1  single system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `i_rx_data`  in  8  received byte.
- `i_rx_valid`  in  1  one-cycle strobe; `i_rx_data` valid this cycle.
- `i_halt`  in  1  pipeline has fetched the halt instruction; level.
- `o_mem_we`  out  1  instruction-memory write enable; one-cycle pulse.
- `o_mem_addr`  out  ADDRESS_BITS  write address.
- `o_mem_data`  out  DATA_BITS  write data.
- `o_pipe_enable`  out  1  drives the fetch/pipeline `enable`.
- `o_pipe_rst`  out  1  active-high pipeline reset (clears PC).
- `o_loaded`  out  1  a complete program is resident.
- `o_busy`  out  1  state is not IDLE.

## Operation
- Command bytes are decoded only in IDLE:
  - `CMD_LOAD` = 0x01 → LOAD.
  - `CMD_RUN` = 0x02 → RUN, only if `o_loaded`.
  - `CMD_STEP` = 0x03 → STEP, only if `o_loaded`.
  - Any other byte, or RUN/STEP while not loaded, is ignored.
- States: IDLE, LOAD, RUN, STEP.
- LOAD:
  - On entry: clear the byte counter and word address to 0, clear `o_loaded`.
  - `o_pipe_rst` = 1 for the whole state.
  - Bytes pack MSB first: byte 0 goes to [31:24] and byte 3 to [7:0].
  - The 4th byte completes a word and triggers a write at the current address. The address then increments.
  - Leave LOAD → IDLE with `o_loaded` = 1 when either:
    - the completed word equals `HALT_WORD` = 0xFFFFFFFF (the halt word is itself written), or
    - the word written at address 2^ADDRESS_BITS−1 completes (memory full, no wrap).
  - Command values have no meaning inside LOAD; every byte is payload.
- RUN:
  - `o_pipe_enable` = 1 every cycle.
  - When `i_halt` is sampled high: → IDLE, and `o_pipe_enable` = 0 from the next cycle. `o_loaded` stays 1, so RUN can be re-issued.
- STEP:
  - `o_pipe_enable` = 0 except for exactly one cycle after each accepted `CMD_STEP` byte.
  - `CMD_EXIT` = 0x04 → IDLE. Other bytes are ignored.
  - `i_halt` sampled high → IDLE. A step pulse already scheduled is still delivered.
- Entering RUN or STEP from IDLE pulses `o_pipe_rst` for 1 cycle so the PC restarts at 0. `o_pipe_enable` is held 0 during that cycle.
- Reset values: state IDLE, `o_mem_we` 0, `o_mem_addr` 0, `o_mem_data` 0, `o_pipe_enable` 0, `o_pipe_rst` 1 (pipeline held in reset until the first RUN/STEP), `o_loaded` 0, `o_busy` 0, byte counter 0.
- Reset in mid-LOAD discards the partial word and clears `o_loaded`. The memory contents are not cleared.

## Timing
- All outputs are registered.
- Byte accepted at cycle t:
  - a command transition is visible at t+1;
  - if it completes a word, `o_mem_we` = 1 at t+1 for one cycle, with address and data stable that cycle.
- Back-to-back `i_rx_valid` on consecutive cycles must be sustained with no lost bytes; there is no back-pressure.
- RUN accepted at t:
  - `o_pipe_rst` = 1 at t+1;
  - `o_pipe_enable` = 1 from t+2.
- STEP byte accepted at t (in STEP): `o_pipe_enable` = 1 at t+1 only.
- `i_halt` high at t: `o_pipe_enable` = 0 at t+1 and the state is IDLE at t+1.
- `o_busy` follows the state register.

## Structure
- Shared package `debug_pkg`: command byte constants, `HALT_WORD`, state enumeration (2-bit).
- Sub-module `byte_packer`:
  - byte → DATA_BITS shift register with a 2-bit counter;
  - ports: clear, `i_valid`, `i_byte`, `o_word`, `o_word_valid`.
- The controller FSM, address counter and enable/reset generation stay in `program_loader`.

## Test plan
- Reset, then LOAD 0x01 followed by bytes 12 34 56 78, FF FF FF FF → writes 0x12345678 @0 and 0xFFFFFFFF @1; `o_loaded` = 1; state IDLE; exactly 2 `o_mem_we` pulses.
- RUN 0x02 before any load → ignored: `o_pipe_enable` stays 0, `o_busy` 0.
- After load: RUN, hold `i_halt` low 10 cycles, then raise it → `o_pipe_rst` pulse at t+1, enable high for cycles t+2…, enable low the cycle after `i_halt`, state IDLE.
- STEP, then 3× 0x03 spaced 5 cycles apart, then 0x04 → exactly three single-cycle enable pulses; return to IDLE.
- LOAD 256 non-halt words with valid on every cycle → 256 writes at addresses 0…255 with no wrap; `o_loaded` = 1 after the last write.
- `rst` after 2 payload bytes of LOAD → all outputs at reset values next cycle; `o_loaded` 0; a new LOAD restarts at address 0.

Source files
------------

// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - command bytes, halt word and controller state encoding for the program loader
package debug_pkg;

    localparam logic [7:0]  CMD_LOAD  = 8'h01;
    localparam logic [7:0]  CMD_RUN   = 8'h02;
    localparam logic [7:0]  CMD_STEP  = 8'h03;
    localparam logic [7:0]  CMD_EXIT  = 8'h04;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs a byte stream MSB-first into DATA_BITS-wide words
module byte_packer #(
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 i_valid,
    input  logic [7:0]           i_byte,
    output logic [DATA_BITS-1:0] o_word,
    output logic                 o_word_valid
);

    localparam int NBYTES   = DATA_BITS / 8;
    localparam int CNT_BITS = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(NBYTES - 1);

    logic [DATA_BITS-1:0] shift_q;
    logic [CNT_BITS-1:0]  cnt_q;

    // The completed word is presented in the same cycle as its last byte so the
    // caller can register the memory write exactly one cycle after that byte.
    assign o_word       = (shift_q << 8) | DATA_BITS'(i_byte);
    assign o_word_valid = i_valid && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (i_valid) begin
            shift_q <= o_word;
            cnt_q   <= (cnt_q == LAST) ? '0 : cnt_q + CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a program from the debug byte stream and runs or single-steps the pipeline
module program_loader
    import debug_pkg::*;
#(
    parameter int ADDRESS_BITS = 8,
    parameter int DATA_BITS    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_valid,
    input  logic                    i_halt,
    output logic                    o_mem_we,
    output logic [ADDRESS_BITS-1:0] o_mem_addr,
    output logic [DATA_BITS-1:0]    o_mem_data,
    output logic                    o_pipe_enable,
    output logic                    o_pipe_rst,
    output logic                    o_loaded,
    output logic                    o_busy
);

    localparam logic [DATA_BITS-1:0]    HALT      = DATA_BITS'(HALT_WORD);
    localparam logic [ADDRESS_BITS-1:0] LAST_ADDR = '1;

    state_t                  state;
    logic [ADDRESS_BITS-1:0] wr_addr;
    logic                    load_start;
    logic                    word_valid;
    logic [DATA_BITS-1:0]    word;

    assign load_start = (state == ST_IDLE) && i_rx_valid && (i_rx_data == CMD_LOAD);

    byte_packer #(
        .DATA_BITS (DATA_BITS)
    ) u_packer (
        .clk          (clk),
        .clear        (rst | load_start),
        .i_valid      ((state == ST_LOAD) && i_rx_valid),
        .i_byte       (i_rx_data),
        .o_word       (word),
        .o_word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            wr_addr       <= '0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_data    <= '0;
            o_pipe_enable <= 1'b0;
            o_pipe_rst    <= 1'b1;
            o_loaded      <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_mem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_pipe_enable <= 1'b0;
                    if (i_rx_valid) begin
                        if (i_rx_data == CMD_LOAD) begin
                            state      <= ST_LOAD;
                            o_busy     <= 1'b1;
                            o_loaded   <= 1'b0;
                            o_pipe_rst <= 1'b1;
                            wr_addr    <= '0;
                        end else if (i_rx_data == CMD_RUN && o_loaded) begin
                            state      <= ST_RUN;
                            o_busy     <= 1'b1;
                            o_pipe_rst <= 1'b1;
                        end else if (i_rx_data == CMD_STEP && o_loaded) begin
                            state      <= ST_STEP;
                            o_busy     <= 1'b1;
                            o_pipe_rst <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    o_pipe_rst    <= 1'b1;
                    o_pipe_enable <= 1'b0;
                    if (word_valid) begin
                        o_mem_we   <= 1'b1;
                        o_mem_addr <= wr_addr;
                        o_mem_data <= word;
                        wr_addr    <= wr_addr + 1'b1;
                        if (word == HALT || wr_addr == LAST_ADDR) begin
                            state    <= ST_IDLE;
                            o_busy   <= 1'b0;
                            o_loaded <= 1'b1;
                        end
                    end
                end
                // Halt is a stale level from the previous run while the PC is being
                // reset, so it is only honoured once o_pipe_rst has dropped.
                ST_RUN: begin
                    o_pipe_rst <= 1'b0;
                    if (i_halt && !o_pipe_rst) begin
                        state         <= ST_IDLE;
                        o_busy        <= 1'b0;
                        o_pipe_enable <= 1'b0;
                    end else begin
                        o_pipe_enable <= 1'b1;
                    end
                end
                ST_STEP: begin
                    o_pipe_rst    <= 1'b0;
                    o_pipe_enable <= 1'b0;
                    if ((i_halt && !o_pipe_rst) || (i_rx_valid && i_rx_data == CMD_EXIT)) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end else if (i_rx_valid && i_rx_data == CMD_STEP) begin
                        o_pipe_enable <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
